key_event_decoder: RTL and testbench

Consumes the clean level from the input debouncer and classifies key activity into one-cycle event pulses: short press, long press, double click, release, and optional auto-repeat. It sits between the debouncer output and the control/UI logic. All thresholds are runtime inputs in clock cycles, matching the debouncer's runtime debounce_time_i style.

---
 rtl/key_pkg.sv | 25 ++
 rtl/key_event_decoder_if.sv | 32 +++
 rtl/key_edge_detect.sv | 26 ++
 rtl/key_event_decoder.sv | 165 ++++++++++++++++
 tb/tb_key_event_decoder.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key event decoder: state encoding, default
// counter width and the event code set used when events are muxed onto one bus.
package key_pkg;

    // Default width of the cycle counter and of the threshold inputs
    localparam int KEY_CNT_W = 32;

    // Decoder states, 3-bit encoding
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS  = 3'd1,
        S_LONG   = 3'd2,
        S_GAP    = 3'd3,
        S_PRESS2 = 3'd4
    } key_state_e;

    // Event codes for merging the individual pulses into a single event bus
    localparam logic [2:0] KEY_EVT_NONE    = 3'd0;
    localparam logic [2:0] KEY_EVT_SHORT   = 3'd1;
    localparam logic [2:0] KEY_EVT_LONG    = 3'd2;
    localparam logic [2:0] KEY_EVT_DOUBLE  = 3'd3;
    localparam logic [2:0] KEY_EVT_RELEASE = 3'd4;
    localparam logic [2:0] KEY_EVT_REPEAT  = 3'd5;

endpackage

// File: rtl/key_event_decoder_if.sv
// Interface bundling the key event decoder's control inputs, runtime
// thresholds and event outputs. master drives the key level and thresholds,
// slave is the decoder.
interface key_event_decoder_if
    import key_pkg::*;
#(
    parameter int CNT_W = KEY_CNT_W
);
    logic             enable_i;
    logic             level_i;
    logic [CNT_W-1:0] long_time_i;
    logic [CNT_W-1:0] gap_time_i;
    logic [CNT_W-1:0] repeat_time_i;
    logic             short_press_o;
    logic             long_press_o;
    logic             double_click_o;
    logic             release_o;
    logic             repeat_o;
    logic             held_o;

    modport master (
        output enable_i, level_i, long_time_i, gap_time_i, repeat_time_i,
        input  short_press_o, long_press_o, double_click_o, release_o,
               repeat_o, held_o
    );

    modport slave (
        input  enable_i, level_i, long_time_i, gap_time_i, repeat_time_i,
        output short_press_o, long_press_o, double_click_o, release_o,
               repeat_o, held_o
    );
endinterface

// File: rtl/key_edge_detect.sv
// Two-flop level history producing single-cycle rise/fall strobes.
// Reusable on any already-synchronised level, e.g. the debouncer update path.
module key_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_rise,
    output logic o_fall
);
    logic r_level_q;
    logic r_level_p;

    // Keep current and previous sampled level; reset to released
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level_q <= 1'b0;
            r_level_p <= 1'b0;
        end else begin
            r_level_q <= i_level;
            r_level_p <= r_level_q;
        end
    end

    assign o_rise = r_level_q & ~r_level_p;
    assign o_fall = ~r_level_q & r_level_p;
endmodule

// File: rtl/key_event_decoder.sv
// Key event decoder: turns the debounced key level into one-cycle pulses for
// short press, long press, double click, release and (optionally) auto-repeat.
// Thresholds are live inputs in clock cycles.
// Optional feature macro: KEY_REPEAT_EN enables auto-repeat while in S_LONG;
// without it repeat_o is tied low and repeat_time_i is ignored.
module key_event_decoder
    import key_pkg::*;
#(
    parameter int CNT_W = KEY_CNT_W
) (
    input  logic               clk_i,
    input  logic               rst_N_i,
    key_event_decoder_if.slave bus
);
    logic             w_rise;
    logic             w_fall;
    key_state_e       r_state;
    key_state_e       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_long_thr;
    logic             w_cnt_clr;
    logic             w_short;
    logic             w_long;
    logic             w_dbl;
    logic             w_rel;
    logic             w_held;
    logic             r_short;
    logic             r_long;
    logic             r_dbl;
    logic             r_rel;
    logic             r_held;
`ifdef KEY_REPEAT_EN
    logic             w_rpt;
    logic             r_rpt;
    logic [CNT_W-1:0] w_rpt_thr;
`endif

    key_edge_detect u_edge (
        .i_clk   (clk_i),
        .i_rst_n (rst_N_i),
        .i_level (bus.level_i),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // Saturating increment: the counter parks at all-ones instead of wrapping
    assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
    // A zero long-press threshold behaves as one cycle
    assign w_long_thr = (bus.long_time_i == '0) ? CNT_W'(1) : bus.long_time_i;
`ifdef KEY_REPEAT_EN
    assign w_rpt_thr  = (bus.repeat_time_i == '0) ? CNT_W'(1) : bus.repeat_time_i;
`endif

    // Next-state and event decode; edges take priority over timeouts
    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_short      = 1'b0;
        w_long       = 1'b0;
        w_dbl        = 1'b0;
        w_rel        = 1'b0;
`ifdef KEY_REPEAT_EN
        w_rpt        = 1'b0;
`endif
        if (!bus.enable_i) begin
            w_state_next = S_IDLE;
            w_cnt_clr    = 1'b1;
        end else begin
            w_rel = w_fall;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) w_state_next = S_PRESS;
                end
                S_PRESS: begin
                    if (w_fall) begin
                        w_state_next = S_GAP;
                    end else if (r_cnt >= w_long_thr) begin
                        w_long       = 1'b1;
                        w_state_next = S_LONG;
                    end
                end
                S_LONG: begin
                    if (w_fall) begin
                        w_state_next = S_IDLE;
                    end
`ifdef KEY_REPEAT_EN
                    // Compare the post-edge count so ticks are exactly
                    // repeat_time cycles apart, starting from S_LONG entry
                    else if (w_cnt_inc >= w_rpt_thr) begin
                        w_rpt     = 1'b1;
                        w_cnt_clr = 1'b1;
                    end
`endif
                end
                S_GAP: begin
                    if (w_rise) begin
                        w_state_next = S_PRESS2;
                    end else if (r_cnt >= bus.gap_time_i) begin
                        w_short      = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
                S_PRESS2: begin
                    if (w_fall) begin
                        w_dbl        = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
        w_held = (w_state_next == S_PRESS) || (w_state_next == S_LONG) ||
                 (w_state_next == S_PRESS2);
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_N_i) begin
        if (!rst_N_i) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // Per-state cycle counter, cleared on any state change or repeat tick
    always_ff @(posedge clk_i or negedge rst_N_i) begin
        if (!rst_N_i)                                  r_cnt <= '0;
        else if (w_cnt_clr || (w_state_next != r_state)) r_cnt <= '0;
        else                                           r_cnt <= w_cnt_inc;
    end

    // Registered event outputs
    always_ff @(posedge clk_i or negedge rst_N_i) begin
        if (!rst_N_i) begin
            r_short <= 1'b0;
            r_long  <= 1'b0;
            r_dbl   <= 1'b0;
            r_rel   <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_short <= w_short;
            r_long  <= w_long;
            r_dbl   <= w_dbl;
            r_rel   <= w_rel;
            r_held  <= w_held;
        end
    end

`ifdef KEY_REPEAT_EN
    // Registered auto-repeat tick
    always_ff @(posedge clk_i or negedge rst_N_i) begin
        if (!rst_N_i) r_rpt <= 1'b0;
        else          r_rpt <= w_rpt;
    end
    assign bus.repeat_o = r_rpt;
`else
    logic w_unused_repeat_time;
    assign w_unused_repeat_time = ^bus.repeat_time_i;
    assign bus.repeat_o = 1'b0;
`endif

    assign bus.short_press_o  = r_short;
    assign bus.long_press_o   = r_long;
    assign bus.double_click_o = r_dbl;
    assign bus.release_o      = r_rel;
    assign bus.held_o         = r_held;
endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder: directed key waveforms push the
// expected pulse (cycle, event set) into a queue; a monitor pops and compares
// whenever any pulse output is high.
module tb_key_event_decoder;
    import key_pkg::*;

    localparam int CNT_W = KEY_CNT_W;
    localparam logic [4:0] EV_SHORT = 5'b00001;
    localparam logic [4:0] EV_LONG  = 5'b00010;
    localparam logic [4:0] EV_DBL   = 5'b00100;
    localparam logic [4:0] EV_REL   = 5'b01000;
    localparam logic [4:0] EV_RPT   = 5'b10000;

    typedef struct {
        int         cyc;
        logic [4:0] ev;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   e0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    key_event_decoder_if #(.CNT_W(CNT_W)) bus ();

    key_event_decoder #(.CNT_W(CNT_W)) dut (
        .clk_i   (clk),
        .rst_N_i (rst_n),
        .bus     (bus)
    );

    // Monitor: every pulse must match the head of the expectation queue
    always @(negedge clk) begin
        logic [4:0] got;
        exp_t       e;
        got = {bus.repeat_o, bus.release_o, bus.double_click_o,
               bus.long_press_o, bus.short_press_o};
        if (got != 5'b0) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event cyc=%0d got=%b required=none", cyc, got);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.ev != got) begin
                    n_fail++;
                    $display("FAIL event cyc=%0d got=%b required cyc=%0d ev=%b",
                             cyc, got, e.cyc, e.ev);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missed_event cyc=%0d got=none required cyc=%0d ev=%b",
                     cyc, e.cyc, e.ev);
        end
    end

    // Watchdog bound on the whole run
    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Change the key level at a negedge; e0 is the edge that samples it
    task automatic set_level(input logic v);
        bus.level_i = v;
        e0 = cyc + 1;
    endtask

    task automatic push(input int c, input logic [4:0] ev);
        exp_t e;
        e.cyc = c;
        e.ev  = ev;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_short"}, 32'(bus.short_press_o), 32'd0);
        chk({name, "_long"},  32'(bus.long_press_o),  32'd0);
        chk({name, "_dbl"},   32'(bus.double_click_o), 32'd0);
        chk({name, "_rel"},   32'(bus.release_o),     32'd0);
        chk({name, "_rpt"},   32'(bus.repeat_o),      32'd0);
        chk({name, "_held"},  32'(bus.held_o),        32'd0);
    endtask

    task automatic chk_drained(input string name);
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int f;
        bus.enable_i      = 1'b1;
        bus.level_i       = 1'b0;
        bus.long_time_i   = CNT_W'(100);
        bus.gap_time_i    = CNT_W'(20);
        bus.repeat_time_i = CNT_W'(1000);
        tick(3);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        tick(3);

        // Short press: held 10 cycles
        set_level(1'b1);
        tick(2);
        chk("short_held", 32'(bus.held_o), 32'd1);
        tick(8);
        set_level(1'b0);
        push(e0 + 1, EV_REL);
        push(e0 + 22, EV_SHORT);
        tick(40);
        chk_drained("short");

        // Long press: held 150 cycles
        set_level(1'b1);
        push(e0 + 102, EV_LONG);
        tick(150);
        set_level(1'b0);
        push(e0 + 1, EV_REL);
        tick(40);
        chk_drained("long");

        // Double click: high 10, low 5, high 10, low
        set_level(1'b1);
        tick(10);
        set_level(1'b0);
        push(e0 + 1, EV_REL);
        tick(5);
        set_level(1'b1);
        tick(10);
        set_level(1'b0);
        push(e0 + 1, EV_REL | EV_DBL);
        tick(40);
        chk_drained("double");

        // Fall in the same cycle the long threshold is reached: no long press
        bus.long_time_i = CNT_W'(10);
        set_level(1'b1);
        tick(11);
        set_level(1'b0);
        push(e0 + 1, EV_REL);
        push(e0 + 22, EV_SHORT);
        tick(40);
        chk_drained("fall_at_thr");

        // Zero gap: short press one cycle after release
        bus.long_time_i = CNT_W'(100);
        bus.gap_time_i  = CNT_W'(0);
        set_level(1'b1);
        tick(5);
        set_level(1'b0);
        push(e0 + 1, EV_REL);
        push(e0 + 2, EV_SHORT);
        tick(10);
        chk_drained("gap_zero");

        // Async reset while in S_LONG, key still held across reset release
        bus.gap_time_i  = CNT_W'(20);
        bus.long_time_i = CNT_W'(10);
        set_level(1'b1);
        push(e0 + 12, EV_LONG);
        tick(20);
        chk("long_state_held", 32'(bus.held_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_rst");
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk("held_after_rst", 32'(bus.held_o), 32'd1);
        set_level(1'b0);
        push(e0 + 1, EV_REL);
        push(e0 + 22, EV_SHORT);
        tick(40);
        chk_drained("rst_mid");

        // Enable low for 3 cycles during S_GAP, key pressed while disabled
        bus.long_time_i = CNT_W'(100);
        set_level(1'b1);
        tick(10);
        set_level(1'b0);
        f = e0;
        push(f + 1, EV_REL);
        tick(4);
        bus.enable_i = 1'b0;
        bus.level_i  = 1'b1;
        tick(1);
        chk("disabled_held", 32'(bus.held_o), 32'd0);
        tick(2);
        bus.enable_i = 1'b1;
        tick(30);
        chk("reenable_no_rise", 32'(bus.held_o), 32'd0);
        set_level(1'b0);
        push(e0 + 1, EV_REL);
        tick(10);
        chk_drained("enable");

`ifdef KEY_REPEAT_EN
        // Auto-repeat: long=50, repeat=10, held 100 cycles
        bus.long_time_i   = CNT_W'(50);
        bus.repeat_time_i = CNT_W'(10);
        set_level(1'b1);
        push(e0 + 52, EV_LONG);
        for (int k = 0; k < 4; k++) push(e0 + 62 + 10 * k, EV_RPT);
        tick(100);
        set_level(1'b0);
        push(e0 + 1, EV_REL);
        tick(40);
        chk_drained("repeat");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
